if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter ADDR_W, default 6, instruction-memory byte-address width.
REQ-002 SHALL provide parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-006 SHALL have port flush  input  1  invalidate IF/ID register (insert bubble).
REQ-007 SHALL have port redirect  input  1  taken branch/jump; load PC from redirect_pc.
REQ-008 SHALL have port redirect_pc  input  ADDR_W  branch target byte address.
REQ-009 SHALL have port imem_addr  output  ADDR_W  byte address driven to instruction memory.
REQ-010 SHALL have port imem_data  input  32  instruction word returned combinationally by instruction memory.
REQ-011 SHALL have ports ifid_valid (output, 1), ifid_pc (output, ADDR_W), ifid_pc_plus4 (output, ADDR_W) and ifid_inst (output, 32), forming the IF/ID pipeline register.
REQ-012 SHALL have port fetch_count  output  16  count of instructions accepted into IF/ID.

Function
REQ-013 SHALL drive imem_addr combinationally from the PC register, with zero added latency.
REQ-014 SHALL select next PC by priority: redirect -> {redirect_pc[ADDR_W-1:2],2'b00}; else stall -> hold; else PC+4.
REQ-015 SHALL compute PC+4 modulo 2^ADDR_W (ADDR_W=6: 60 -> 0), with no overflow indication.
REQ-016 SHALL force redirect_pc[1:0] to zero; misaligned targets are truncated, not trapped.
REQ-017 SHALL apply IF/ID update priority at each edge: flush or redirect -> valid=0, inst=NOP_INST, pc and pc_plus4 hold; else stall -> all IF/ID fields hold; else capture valid=1, inst=imem_data, pc=PC, pc_plus4=PC+4.
REQ-018 SHALL, when redirect and stall are asserted together, give redirect precedence for both the PC and the IF/ID register.
REQ-019 SHALL, when flush is asserted alone, continue advancing the PC (PC+4) unless stall is also asserted.
REQ-020 SHALL present an instruction fetched at edge N on the ifid_* outputs from edge N until the next update (1-cycle fetch-to-decode latency).
REQ-021 SHALL implement no state machine beyond the PC and IF/ID registers; the block is a 2-register pipeline stage.

Reset
REQ-022 SHALL, while rst=1, asynchronously set PC=RESET_PC, ifid_valid=0, ifid_inst=NOP_INST, ifid_pc=0, ifid_pc_plus4=0, fetch_count=0.
REQ-023 SHALL, on the first rising edge after rst deasserts, capture the instruction at RESET_PC with valid=1 and move PC to RESET_PC+4.
REQ-024 SHALL, when rst asserts mid-operation, discard any pending redirect, stall or flush.

Configuration
REQ-025 SHALL, with IF_FETCH_CNT_EN defined, increment fetch_count on every edge that performs a capture per REQ-017, saturating at 16'hFFFF.
REQ-026 SHALL, without IF_FETCH_CNT_EN, tie fetch_count to 0, keep the port, and contain no counter flops.

Structure
REQ-027 SHALL place in shared package if_pkg: INST_W=32 and NOP_INST=32'h0000_0033 (add x0,x0,x0).
REQ-028 SHALL instantiate one sub-module pc_reg, containing the PC flop, the next-PC mux and the +4 adder.
REQ-029 SHALL be implementable in 120-400 lines of RTL.

Verification
REQ-030 SHALL cover: reset, then 4 free cycles, memory stub returning {26'h0,addr} -> imem_addr 0,4,8,12,16; ifid_pc 0,4,8,12 with valid=1 and ifid_inst matching.
REQ-031 SHALL cover: stall for 2 cycles while PC=8 -> imem_addr stays 8, ifid_pc stays 4; after release, ifid_pc=8.
REQ-032 SHALL cover: redirect=1, redirect_pc=28 while PC=20 -> next imem_addr=28, ifid_valid=0, ifid_inst=32'h0000_0033; one edge later, ifid_pc=28, valid=1.
REQ-033 SHALL cover: redirect with stall and flush in the same cycle, redirect_pc=0x1F -> PC=28, bubble inserted; then free run from PC=60 -> next imem_addr=0.
REQ-034 SHALL cover: rst pulsed asynchronously between edges mid-run -> outputs reach reset values before the next edge; fetch_count=0 (with IF_FETCH_CNT_EN, count after 5 captures = 5).

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
package if_pkg;

  localparam int INST_W = 32;

  // Bubble instruction: add x0,x0,x0
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0033;

endpackage

// File: rtl/pc_reg.sv
// Program counter: PC flop, next-PC priority mux and the +4 adder.
// Redirect targets are word-aligned by dropping the two low bits.
module pc_reg #(
  parameter int          ADDR_W   = 6,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus4
);

  logic [ADDR_W-1:0] r_pc_p0;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_pc_next;

  // Wraps modulo 2^ADDR_W; carry out is intentionally discarded
  assign w_pc_plus4 = r_pc_p0 + ADDR_W'(4);

  // Next-PC select: redirect beats stall, otherwise sequential
  always_comb begin
    w_pc_next = r_pc_p0;
    if (i_redirect) begin
      w_pc_next = {i_redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (!i_stall) begin
      w_pc_next = w_pc_plus4;
    end
  end

  // PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_p0 <= ADDR_W'(RESET_PC);
    end else begin
      r_pc_p0 <= w_pc_next;
    end
  end

  assign o_pc       = r_pc_p0;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register plus the IF/ID pipeline register.
// Optional build macro IF_FETCH_CNT_EN adds a saturating 16-bit count of
// instructions captured into IF/ID; without it fetch_count reads zero.
module if_stage
  import if_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic              ifid_valid,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pc_plus4,
  output logic [INST_W-1:0] ifid_inst,
  output logic [15:0]       fetch_count
);

  logic [ADDR_W-1:0] w_pc_p0;
  logic [ADDR_W-1:0] w_pc_plus4_p0;
  logic              w_capture;

  logic              r_vld_p1;
  logic [ADDR_W-1:0] r_pc_p1;
  logic [ADDR_W-1:0] r_pc_plus4_p1;
  logic [INST_W-1:0] r_inst_p1;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_pc          (w_pc_p0),
    .o_pc_plus4    (w_pc_plus4_p0)
  );

  // Memory sees the PC register directly, no added latency
  assign imem_addr = w_pc_p0;

  // A real fetch lands in IF/ID only when nothing kills or holds it
  assign w_capture = !flush && !redirect && !stall;

  // ---- IF -> ID boundary ----
  // Bubble on flush/redirect (pc fields hold), hold on stall, else capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1      <= 1'b0;
      r_inst_p1     <= NOP_INST;
      r_pc_p1       <= '0;
      r_pc_plus4_p1 <= '0;
    end else if (flush || redirect) begin
      r_vld_p1      <= 1'b0;
      r_inst_p1     <= NOP_INST;
    end else if (w_capture) begin
      r_vld_p1      <= 1'b1;
      r_inst_p1     <= imem_data;
      r_pc_p1       <= w_pc_p0;
      r_pc_plus4_p1 <= w_pc_plus4_p0;
    end
  end

  assign ifid_valid    = r_vld_p1;
  assign ifid_pc       = r_pc_p1;
  assign ifid_pc_plus4 = r_pc_plus4_p1;
  assign ifid_inst     = r_inst_p1;

`ifdef IF_FETCH_CNT_EN
  logic [15:0] r_fetch_cnt;

  // Saturating count of captures into IF/ID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= '0;
    end else if (w_capture && (r_fetch_cnt != 16'hFFFF)) begin
      r_fetch_cnt <= r_fetch_cnt + 16'd1;
    end
  end

  assign fetch_count = r_fetch_cnt;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random control traffic,
// all checked against a cycle-level behavioural model of the fetch stage.
module tb_if_stage;

  localparam int AW  = 6;
  localparam int NOP = 32'h0000_0033;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          flush;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          ifid_valid;
  logic [AW-1:0] ifid_pc;
  logic [AW-1:0] ifid_pc_plus4;
  logic [31:0]   ifid_inst;
  logic [15:0]   fetch_count;

  int n_vec;
  int n_bad;

  // Behavioural model state
  int m_pc;
  int m_vld;
  int m_id_pc;
  int m_id_pc4;
  int m_inst;
  int m_cnt;

  if_stage #(.ADDR_W(AW), .RESET_PC(0)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_inst     (ifid_inst),
    .fetch_count   (fetch_count)
  );

  // Memory stub: the instruction word is its own address
  assign imem_data = {26'h0, imem_addr};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at t=%0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_vld = 0; m_id_pc = 0; m_id_pc4 = 0; m_inst = NOP; m_cnt = 0;
  endtask

  // One rising edge of the fetch stage, from the stated priority rules
  task automatic model_edge(input bit s, input bit f, input bit r, input int rpc);
    int nxt;
    if (r)       nxt = (rpc / 4) * 4;
    else if (s)  nxt = m_pc;
    else         nxt = (m_pc + 4) % 64;
    if (f || r) begin
      m_vld = 0; m_inst = NOP;
    end else if (!s) begin
      m_vld = 1; m_inst = m_pc; m_id_pc = m_pc; m_id_pc4 = (m_pc + 4) % 64;
      if (m_cnt < 65535) m_cnt++;
    end
    m_pc = nxt;
  endtask

  task automatic check_all(input string tag);
    int exp_cnt;
`ifdef IF_FETCH_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    check({tag, ".imem_addr"},  32'(imem_addr),     32'(m_pc));
    check({tag, ".valid"},      32'(ifid_valid),    32'(m_vld));
    check({tag, ".ifid_pc"},    32'(ifid_pc),       32'(m_id_pc));
    check({tag, ".pc_plus4"},   32'(ifid_pc_plus4), 32'(m_id_pc4));
    check({tag, ".inst"},       ifid_inst,          32'(m_inst));
    check({tag, ".fetch_count"},32'(fetch_count),   32'(exp_cnt));
  endtask

  // Apply controls, take one edge, then compare just after it
  task automatic cyc(input string tag, input bit s, input bit f, input bit r, input int rpc);
    stall = s; flush = f; redirect = r; redirect_pc = AW'(rpc);
    @(posedge clk);
    #1;
    model_edge(s, f, r, rpc);
    check_all(tag);
  endtask

  // Assert rst between edges with controls pending, check, then release
  task automatic async_reset(input string tag);
    #3;
    stall = 1'b1; flush = 1'b1; redirect = 1'b1; redirect_pc = 6'd40;
    rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
    model_reset();
    #2;
    check_all("reset");
    rst = 1'b0;

    // Free run: PC 0,4,8 ... IF/ID trails by one edge
    for (int i = 0; i < 2; i++) cyc("free", 0, 0, 0, 0);
    // Stall with PC=8: both registers hold
    cyc("stall", 1, 0, 0, 0);
    cyc("stall", 1, 0, 0, 0);
    cyc("release", 0, 0, 0, 0);
    cyc("free", 0, 0, 0, 0);
    cyc("free", 0, 0, 0, 0);
    // PC=20: redirect to 28 inserts a bubble, then 28 is captured
    cyc("redirect", 0, 0, 1, 28);
    cyc("after_redir", 0, 0, 0, 0);
    // Flush alone: bubble but PC advances
    cyc("flush", 0, 1, 0, 0);
    cyc("flush_stall", 1, 1, 0, 0);
    // Redirect + stall + flush with misaligned target 0x1F -> 28
    cyc("redir_all", 1, 1, 1, 31);
    cyc("free", 0, 0, 0, 0);
    // Wrap: PC=60 -> 0
    cyc("to60", 0, 0, 1, 60);
    cyc("wrap", 0, 0, 0, 0);
    cyc("wrap2", 0, 0, 0, 0);
    // Mid-run async reset with pending controls; first edge fetches 0
    async_reset("rst1");
    for (int i = 0; i < 5; i++) cyc("post_rst", 0, 0, 0, 0);

    // Random control traffic
    for (int i = 0; i < 400; i++) begin
      bit s, f, r;
      s = ($urandom_range(99) < 25);
      f = ($urandom_range(99) < 15);
      r = ($urandom_range(99) < 15);
      if ($urandom_range(99) < 2) async_reset("rnd_rst");
      else cyc("rnd", s, f, r, int'($urandom_range(63)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
